// File: rtl/vga_pkg.sv
// VGA timing defaults (640x480@60, 25 MHz) and RGB565 colour constants.
// Shared by vga_ctrl and the screen generators.
package vga_pkg;

  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_VALID = 640;
  localparam int VGA_H_FRONT = 16;

  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_VALID = 480;
  localparam int VGA_V_FRONT = 10;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  localparam logic [9:0] PIX_NONE = 10'h3FF;

endpackage

// File: rtl/vga_ctrl.sv
// VGA timing generator: h/v counters, active/sync decode, one output stage.
// Ports: vga_clk, sys_rst (async, high), pix_data in; pix_x/pix_y (comb),
// hsync/vsync (low), rgb, rgb_valid, frame_start (registered) out.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int H_VALID = VGA_H_VALID,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int V_VALID = VGA_V_VALID,
  parameter int V_FRONT = VGA_V_FRONT
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  // exclusive upper bounds of the active window
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [15:0] rgb_q, rgb_d;
  logic        rgb_valid_q, rgb_valid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        active;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) v_cnt_d = '0;
      else                   v_cnt_d = v_cnt_q + 10'd1;
    end

    active = (h_cnt_q >= H_START) && (h_cnt_q < H_END)
          && (v_cnt_q >= V_START) && (v_cnt_q < V_END);

    pix_x = PIX_NONE;
    pix_y = PIX_NONE;
    if (active) begin
      pix_x = h_cnt_q - H_START;
      pix_y = v_cnt_q - V_START;
    end

    rgb_d         = active ? pix_data : BLACK;
    rgb_valid_d   = active;
    hsync_d       = !(h_cnt_q < H_SW);
    vsync_d       = !(v_cnt_q < V_SW);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= BLACK;
      rgb_valid_q   <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      rgb_valid_q   <= rgb_valid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb         = rgb_q;
  assign rgb_valid   = rgb_valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: full-size instance for line/active timing,
// scaled-down instance for whole-frame wrap, latency and reset restart.
module tb_vga_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  // full-size instance
  logic [15:0] pd;
  logic [9:0]  px, py;
  logic        hs, vs, vld, fs;
  logic [15:0] rgb;

  assign pd = 16'hFFFF;

  vga_ctrl u_dut (
    .vga_clk(clk), .sys_rst(rst), .pix_data(pd),
    .pix_x(px), .pix_y(py), .hsync(hs), .vsync(vs),
    .rgb(rgb), .rgb_valid(vld), .frame_start(fs)
  );

  // scaled instance: H total 13 (active h 5..10), V total 9 (active v 4..6)
  logic [15:0] s_pd;
  logic [9:0]  s_px, s_py;
  logic        s_hs, s_vs, s_vld, s_fs;
  logic [15:0] s_rgb;

  assign s_pd = {6'b0, s_px};

  vga_ctrl #(
    .H_SYNC(3), .H_BACK(2), .H_VALID(6), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VALID(3), .V_FRONT(2)
  ) u_small (
    .vga_clk(clk), .sys_rst(rst), .pix_data(s_pd),
    .pix_x(s_px), .pix_y(s_py), .hsync(s_hs), .vsync(s_vs),
    .rgb(s_rgb), .rgb_valid(s_vld), .frame_start(s_fs)
  );

  int total = 0;
  int bad = 0;
  int n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  // n = clocks since reset release; outputs sampled 1 time unit after edge n
  typedef struct {
    int          n;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [15:0] rgb;
    logic        vld;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int nn, input logic [9:0] x, input logic [9:0] y,
                     input logic [15:0] c, input logic v, input logic h,
                     input logic vv, input logic f);
    vec_t e;
    e.n = nn; e.px = x; e.py = y; e.rgb = c;
    e.vld = v; e.hs = h; e.vs = vv; e.fs = f;
    tbl.push_back(e);
  endtask

  task automatic chk_rst(input string tag, input logic [9:0] x,
                         input logic [9:0] y, input logic [15:0] c,
                         input logic v, input logic h, input logic vv,
                         input logic f);
    chk({tag, " rgb"}, {16'b0, c}, 32'h0);
    chk({tag, " vld"}, {31'b0, v}, 32'h0);
    chk({tag, " hs"}, {31'b0, h}, 32'h1);
    chk({tag, " vs"}, {31'b0, vv}, 32'h1);
    chk({tag, " fs"}, {31'b0, f}, 32'h0);
    chk({tag, " px"}, {22'b0, x}, 32'h3FF);
    chk({tag, " py"}, {22'b0, y}, 32'h3FF);
  endtask

  initial begin
    int blank_err;
    int hs_lo;
    int vs_lo;
    int s_hs_lo, s_vs_lo, s_vld_hi, gap_fs;
    int pulses[$];
    logic [9:0] prev_px;
    string nm;

    add(1,     10'h3FF, 10'h3FF, 16'h0,    0, 0, 0, 1);
    add(2,     10'h3FF, 10'h3FF, 16'h0,    0, 0, 0, 0);
    add(96,    10'h3FF, 10'h3FF, 16'h0,    0, 0, 0, 0);
    add(97,    10'h3FF, 10'h3FF, 16'h0,    0, 1, 0, 0);
    add(800,   10'h3FF, 10'h3FF, 16'h0,    0, 1, 0, 0);
    add(801,   10'h3FF, 10'h3FF, 16'h0,    0, 0, 0, 0);
    add(1600,  10'h3FF, 10'h3FF, 16'h0,    0, 1, 0, 0);
    add(1601,  10'h3FF, 10'h3FF, 16'h0,    0, 0, 1, 0);
    add(27401, 10'h3FF, 10'h3FF, 16'h0,    0, 1, 1, 0);
    add(28144, 10'd0,   10'd0,   16'h0,    0, 1, 1, 0);
    add(28145, 10'd1,   10'd0,   16'hFFFF, 1, 1, 1, 0);
    add(28783, 10'd639, 10'd0,   16'hFFFF, 1, 1, 1, 0);
    add(28784, 10'h3FF, 10'h3FF, 16'hFFFF, 1, 1, 1, 0);
    add(28785, 10'h3FF, 10'h3FF, 16'h0,    0, 1, 1, 0);

    // held in reset across several edges
    repeat (3) @(posedge clk);
    #1;
    chk_rst("rst0", px, py, rgb, vld, hs, vs, fs);

    blank_err = 0;
    hs_lo = 0;
    vs_lo = 0;
    release_rst();
    for (int i = 0; i < tbl.size(); i++) begin
      while (n < tbl[i].n) begin
        step();
        if (!vld && rgb != 16'h0) blank_err++;
        if (n <= 1600 && !hs) hs_lo++;
        if (!vs) vs_lo++;
        if (n >= 28144 && n <= 28783) begin
          chk("sweep px", {22'b0, px}, 32'(n - 28144));
          chk("sweep py", {22'b0, py}, 32'h0);
        end
      end
      nm = $sformatf("v%0d", tbl[i].n);
      chk({nm, " px"},  {22'b0, px},  {22'b0, tbl[i].px});
      chk({nm, " py"},  {22'b0, py},  {22'b0, tbl[i].py});
      chk({nm, " rgb"}, {16'b0, rgb}, {16'b0, tbl[i].rgb});
      chk({nm, " vld"}, {31'b0, vld}, {31'b0, tbl[i].vld});
      chk({nm, " hs"},  {31'b0, hs},  {31'b0, tbl[i].hs});
      chk({nm, " vs"},  {31'b0, vs},  {31'b0, tbl[i].vs});
      chk({nm, " fs"},  {31'b0, fs},  {31'b0, tbl[i].fs});
    end
    chk("blank rgb errs", 32'(blank_err), 32'h0);
    chk("hs low 2 lines", 32'(hs_lo), 32'd192);
    chk("vs low clocks", 32'(vs_lo), 32'd1600);

    // asynchronous reset mid-frame, no clock edge in between
    #5;
    rst = 1'b1;
    #1;
    chk_rst("arst full", px, py, rgb, vld, hs, vs, fs);
    repeat (3) @(posedge clk);
    #1;
    chk_rst("arst hold", px, py, rgb, vld, hs, vs, fs);

    // three frames of the scaled instance (117 clocks each)
    s_hs_lo = 0;
    s_vs_lo = 0;
    s_vld_hi = 0;
    release_rst();
    prev_px = s_px;
    for (int k = 1; k <= 351; k++) begin
      step();
      if (n == 1) chk("restart fs n1", {31'b0, fs}, 32'h1);
      if (n == 2) chk("restart fs n2", {31'b0, fs}, 32'h0);
      if (n == 97) chk("restart hs n97", {31'b0, hs}, 32'h1);
      if (s_vld) chk("s latency rgb", {16'b0, s_rgb}, {22'b0, prev_px});
      else       chk("s blank rgb", {16'b0, s_rgb}, 32'h0);
      if (s_fs) pulses.push_back(n);
      if (n <= 117) begin
        if (!s_hs) s_hs_lo++;
        if (!s_vs) s_vs_lo++;
        if (s_vld) s_vld_hi++;
      end
      prev_px = s_px;
    end
    chk("s fs count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("s fs 1st", 32'(pulses[0]), 32'd1);
      chk("s fs 2nd", 32'(pulses[1]), 32'd118);
      chk("s fs 3rd", 32'(pulses[2]), 32'd235);
    end
    chk("s hs low/frame", 32'(s_hs_lo), 32'd27);
    chk("s vs low/frame", 32'(s_vs_lo), 32'd26);
    chk("s vld/frame", 32'(s_vld_hi), 32'd18);

    // land inside the active window (frame pos 409 -> v=4, h=6)
    while (n < 410) step();
    chk("s pre-rst vld", {31'b0, s_vld}, 32'h1);
    #5;
    rst = 1'b1;
    #1;
    chk_rst("arst small", s_px, s_py, s_rgb, s_vld, s_hs, s_vs, s_fs);
    repeat (3) @(posedge clk);
    release_rst();
    step();
    chk("s restart fs n1", {31'b0, s_fs}, 32'h1);
    gap_fs = 0;
    while (n < 117) begin
      step();
      if (s_fs) gap_fs++;
    end
    chk("s no fs mid-frame", 32'(gap_fs), 32'h0);
    chk("s wrap px", {22'b0, s_px}, 32'h3FF);
    step();
    chk("s wrap fs n118", {31'b0, s_fs}, 32'h1);
    step();
    chk("s wrap fs n119", {31'b0, s_fs}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
